sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_pick.sv | 30 +++
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the two-port SRAM arbiter:
//   - default word-address / data widths (16K x 32 data SRAM)
//   - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int unsigned SRAM_ARB_ADDR_W = 14;
  localparam int unsigned SRAM_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } sram_arb_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// -----------------------------------------------------------------------------
// sram_arb_pick
// Combinational grant selection between two requesters.
//   req0  : port 0 request
//   req1  : port 1 request
//   last  : index of the port served last
//   gnt   : granted port index (0 or 1); 0 when nothing is requested
//   valid : at least one request is present
// A tie goes to the port that was not served last. Tying last to 1 turns this
// into fixed priority for port 0.
// -----------------------------------------------------------------------------
module sram_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    gnt   = 1'b0;
    if (req0 && req1) begin
      gnt = ~last;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Arbitrates two requesters (port 0: pipeline data memory, port 1: loader /
// debug) onto one single-port SRAM with combinational read data. Each
// transaction walks IDLE -> ACCESS -> DONE, so at most one transaction is
// completed every three cycles. The SRAM itself lives in the parent.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req0/req1               level requests, held until ack
//   addr0/addr1             per-port word address
//   we0/we1                 per-port write enable (1 = write)
//   wd0/wd1                 per-port write data
//   ack0/ack1               one-cycle completion pulse
//   rdata0/rdata1           per-port read data (valid with ack)
//   sram_addr/sram_we/sram_wd  SRAM command
//   sram_rd                 SRAM combinational read data
//
// Build option:
//   SRAM_ARB_ROUND_ROBIN_EN  defined: ties go to the port not served last.
//                            undefined: port 0 always wins a tie.
// -----------------------------------------------------------------------------
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ARB_ADDR_W,
  parameter int unsigned DATA_W = SRAM_ARB_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_wd,
  input  logic [DATA_W-1:0] sram_rd
);

  sram_arb_state_e   state_q, state_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic pick_gnt;
  logic pick_valid;
  logic last_srv;

  sram_arb_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_srv),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && pick_valid) begin
      last_d = pick_gnt;
    end
  end

  // Resetting to 1 gives port 0 the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_srv = last_q;
`else
  assign last_srv = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wd_d     = wd_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          port_d  = pick_gnt;
          addr_d  = pick_gnt ? addr1 : addr0;
          we_d    = pick_gnt ? we1   : we0;
          wd_d    = pick_gnt ? wd1   : wd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          if (port_q) begin
            rdata1_d = sram_rd;
          end else begin
            rdata0_d = sram_rd;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wd_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wd_q     <= wd_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Write strobe is gated by state so only the ACCESS cycle can write; the
  // async reset drops it immediately, aborting any write in flight.
  assign sram_addr = addr_q;
  assign sram_wd   = wd_q;
  assign sram_we   = (state_q == ACCESS) && we_q;
  assign ack0      = (state_q == DONE) && !port_q;
  assign ack1      = (state_q == DONE) &&  port_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule
